front_scan_seq: RTL
===================

FRONT_SCAN_SEQ -- requirements
Module: front_scan_seq

Interface
REQ-001 SHALL have parameter NPHASE, default 8, meaning ce ticks per sprite slot (fixed at 8; other values unsupported).
REQ-002 SHALL have port clk  in  1  system clock; every register updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port ce  in  1  pixel clock enable; the sequencer advances only on clk edges where ce=1.
REQ-005 SHALL have port line_start  in  1  single-clk pulse that starts a sprite scan for the next line.
REQ-006 SHALL have port fn  in  6  number of sprite slots to scan, 0..63; sampled at scan start.
REQ-007 SHALL have port cpu_req  in  1  CPU request for front sprite RAM.
REQ-008 SHALL have port cpu_ack  out  1  CPU access granted this clk.
REQ-009 SHALL have port v_c  out  1  RAM address mux select: 1 selects the CPU address, 0 selects the scan address.
REQ-010 SHALL have ports fh  out  5  and h3  out  1, which together form the sprite slot index {fh,h3}.
REQ-011 SHALL have ports vlk, f1ck, lc  out  1 each: single-clk latch strobes.
REQ-012 SHALL have port ld_n  out  1  shifter load, active-low, one clk wide.
REQ-013 SHALL have ports busy  out  1  (scan or drain in progress) and line_done  out  1  (one-clk pulse when the line completes).

Function
REQ-014 SHALL implement the states IDLE, SCAN and DRAIN, plus a 3-bit phase counter and a 6-bit slot index.
REQ-015 IDLE + line_start: if fn=0, line_done SHALL pulse on the next clk and the state SHALL stay IDLE; otherwise the block SHALL latch fn, clear index and phase, and enter SCAN.
REQ-016 SCAN: on each ce the phase SHALL increment modulo 8.
- On ce at phase 7 with index = fn_latched-1, the state SHALL go to DRAIN and the phase SHALL clear.
- On ce at phase 7 otherwise, the index SHALL increment.
REQ-017 DRAIN: the block SHALL count 8 ce ticks with no index change, then pulse line_done and return to IDLE.
REQ-018 Strobes SHALL be registered; the conditions below refer to the phase before the edge.
- A ce edge in SCAN at phase 1 SHALL set vlk=1 for the next clk.
- A ce edge in SCAN at phase 3 SHALL set f1ck=1 for the next clk.
- A ce edge at phase 7, in SCAN or DRAIN, SHALL set lc=1 and ld_n=0 for the next clk.
REQ-019 In DRAIN, vlk SHALL be suppressed and f1ck SHALL still fire, so that the last slot flushes through the pipeline.
REQ-020 {fh,h3} SHALL equal the slot index: registered, stable across all 8 phases of a slot, and 0 in IDLE.
REQ-021 Arbitration: video SHALL have priority over the CPU.
- In IDLE, cpu_req SHALL give cpu_ack=1 and v_c=1 on the following clk, held while cpu_req stays asserted.
- In SCAN or DRAIN, v_c SHALL be 1 only during phases 4 and 5, and cpu_ack SHALL equal cpu_req during that window.
- In SCAN or DRAIN outside phases 4 and 5, v_c and cpu_ack SHALL be 0.
REQ-022 When line_start arrives while the CPU is granted in IDLE, cpu_ack and v_c SHALL drop on the same clk that SCAN is entered.
REQ-023 line_start during SCAN or DRAIN SHALL abort the current line with no line_done pulse and restart per REQ-015 using the current fn.
REQ-024 A change of fn during SCAN SHALL have no effect until the next line_start.
REQ-025 The slot index SHALL never exceed 63; with fn=63 the last scanned slot is 62 (slots 0..fn-1).
REQ-026 With ce=0, all state, index and phase SHALL hold, and all strobes SHALL be at their inactive levels.
REQ-027 busy SHALL be 1 in SCAN and DRAIN, and 0 in IDLE.

Reset
REQ-028 While rst=1, the state SHALL be IDLE; phase and index SHALL be 0; fh=0, h3=0; vlk=f1ck=lc=0; ld_n=1; cpu_ack=0; v_c=0; busy=0; line_done=0.
REQ-029 Reset asserted mid-scan SHALL take effect on the next clk edge regardless of ce, and no line_done SHALL be issued.

Verification
REQ-030 The bench SHALL run: ce=1 continuous, fn=3, line_start pulse -> busy for 24+8 ce, {fh,h3} goes 0,1,2, 3 vlk, 4 f1ck, 4 ld_n pulses, then one line_done.
REQ-031 The bench SHALL run: fn=0, line_start -> line_done exactly 1 clk later, busy never 1, no strobes.
REQ-032 The bench SHALL run: ce every 4th clk, fn=2 -> each strobe stays exactly 1 clk wide, and the slot timing scales by 4.
REQ-033 The bench SHALL run: cpu_req held high across line_start -> cpu_ack=1 in IDLE, dropping to 0 on SCAN entry, then high only in phases 4-5 of each slot.
REQ-034 The bench SHALL run: line_start mid-SCAN at index 5 -> index restarts at 0, no line_done for the aborted line.
REQ-035 The bench SHALL run: rst pulsed at index 10, phase 3 -> all outputs reach their REQ-028 values on the next clk, and no line_done.

Source files
------------

// File: rtl/front_scan_seq.sv
// Front sprite scan sequencer: walks fn sprite slots of NPHASE pixel ticks each, then drains
// the pipeline for one more slot, issuing latch/load strobes and arbitrating RAM access with the CPU.
module front_scan_seq #(
    parameter int NPHASE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       line_start,
    input  logic [5:0] fn,
    input  logic       cpu_req,
    output logic       cpu_ack,
    output logic       v_c,
    output logic [4:0] fh,
    output logic       h3,
    output logic       vlk,
    output logic       f1ck,
    output logic       lc,
    output logic       ld_n,
    output logic       busy,
    output logic       line_done,
    output logic [1:0] state_dbg
);

    localparam logic [2:0] LAST_PHASE = 3'(NPHASE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] phase_q, phase_d;
    logic [5:0] idx_q, idx_d;
    logic [5:0] fn_q, fn_d;
    logic       vlk_q, vlk_d;
    logic       f1ck_q, f1ck_d;
    logic       lc_q, lc_d;
    logic       ld_n_q, ld_n_d;
    logic       done_q, done_d;
    logic       v_c_q, v_c_d;
    logic       ack_q, ack_d;
    logic       busy_d;
    logic       win_d;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        fn_d    = fn_q;
        vlk_d   = 1'b0;
        f1ck_d  = 1'b0;
        lc_d    = 1'b0;
        ld_n_d  = 1'b1;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        win_d   = 1'b0;
        v_c_d   = 1'b0;
        ack_d   = 1'b0;

        // line_start wins over everything, including an in-flight line (abort, no done pulse).
        if (line_start) begin
            phase_d = 3'd0;
            idx_d   = 6'd0;
            if (fn == 6'd0) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = S_SCAN;
                fn_d    = fn;
            end
        end else if (ce) begin
            case (state_q)
                S_SCAN: begin
                    phase_d = phase_q + 3'd1;
                    vlk_d   = (phase_q == 3'd1);
                    f1ck_d  = (phase_q == 3'd3);
                    if (phase_q == LAST_PHASE) begin
                        lc_d   = 1'b1;
                        ld_n_d = 1'b0;
                        if (idx_q == fn_q - 6'd1) begin
                            state_d = S_DRAIN;
                            phase_d = 3'd0;
                        end else begin
                            idx_d = idx_q + 6'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    // One extra slot time lets the last slot flush; no vlk, index frozen.
                    phase_d = phase_q + 3'd1;
                    f1ck_d  = (phase_q == 3'd3);
                    if (phase_q == LAST_PHASE) begin
                        lc_d    = 1'b1;
                        ld_n_d  = 1'b0;
                        state_d = S_IDLE;
                        idx_d   = 6'd0;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Video owns the RAM while busy except during phases 4-5 of each slot.
        busy_d = (state_d != S_IDLE);
        win_d  = busy_d && ((phase_d == 3'd4) || (phase_d == 3'd5));
        v_c_d  = busy_d ? win_d : cpu_req;
        ack_d  = cpu_req && (busy_d ? win_d : 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= 3'd0;
            idx_q   <= 6'd0;
            fn_q    <= 6'd0;
            vlk_q   <= 1'b0;
            f1ck_q  <= 1'b0;
            lc_q    <= 1'b0;
            ld_n_q  <= 1'b1;
            done_q  <= 1'b0;
            v_c_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            fn_q    <= fn_d;
            vlk_q   <= vlk_d;
            f1ck_q  <= f1ck_d;
            lc_q    <= lc_d;
            ld_n_q  <= ld_n_d;
            done_q  <= done_d;
            v_c_q   <= v_c_d;
            ack_q   <= ack_d;
        end
    end

    assign {fh, h3}  = idx_q;
    assign vlk       = vlk_q;
    assign f1ck      = f1ck_q;
    assign lc        = lc_q;
    assign ld_n      = ld_n_q;
    assign line_done = done_q;
    assign v_c       = v_c_q;
    assign cpu_ack   = ack_q;
    assign busy      = (state_q != S_IDLE);
    assign state_dbg = state_q;

endmodule
